alu_cmd_driver: RTL and testbench



---
 rtl/alu_cmd_driver_pkg.sv | 18 +
 rtl/alu_cmd_driver_cmd_fifo.sv | 43 ++++
 rtl/alu_cmd_driver.sv | 121 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM encodings, default widths.
package alu_cmd_driver_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OP_WIDTH   = 3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_ISSUE    = 2'b01;
    localparam logic [1:0] ST_WAIT_RES = 2'b10;

endpackage

// File: rtl/alu_cmd_driver_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full/empty
// fall out of a plain pointer compare.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: reads are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command-issue stage: buffers pushed ALU commands, issues them one at a time
// over valid/ready, waits for each result with a timeout, and reports status.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OP_WIDTH   = DEF_OP_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_push,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  cmd_full,
    output logic                  alu_valid,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic                  alu_ready,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic [DATA_WIDTH-1:0] last_result,
    output logic [15:0]           done_count,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  overflow_err
);
    localparam int CW = OP_WIDTH + 2 * DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT);

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic [15:0]           done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  overflow_q, overflow_d;

    logic [CW-1:0]         head;
    logic                  fifo_full, fifo_empty, push_ok, pop, nonempty_next;

    assign push_ok       = cmd_push && !fifo_full;
    assign pop           = (state_q == ST_ISSUE) && alu_ready;
    // Only used in WAIT_RES, where no pop can happen.
    assign nonempty_next = !fifo_empty || push_ok;

    cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push_ok),
        .wdata_i ({cmd_op, cmd_a, cmd_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q || (cmd_push && fifo_full);
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (alu_ready) begin
                    state_d = ST_WAIT_RES;
                    timer_d = '0;
                end
            end
            ST_WAIT_RES: begin
                // A result arriving on the timeout edge takes priority.
                if (res_valid) begin
                    last_d  = res_data;
                    done_d  = done_q + 16'd1;
                    state_d = nonempty_next ? ST_ISSUE : ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = nonempty_next ? ST_ISSUE : ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            last_q     <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign alu_valid    = (state_q == ST_ISSUE);
    assign alu_op       = alu_valid ? head[CW-1 -: OP_WIDTH] : '0;
    assign alu_a        = alu_valid ? head[2*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
    assign alu_b        = alu_valid ? head[DATA_WIDTH-1:0] : '0;
    assign cmd_full     = fifo_full;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign last_result  = last_q;
    assign done_count   = done_q;
    assign timeout_err  = timeout_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a per-cycle vector table for the single
// command flow plus hand sequences for fill/overflow, stall, timeout and reset.
module tb_alu_cmd_driver;
    import alu_cmd_driver_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_push = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic        cmd_full, alu_valid;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_ready = 1'b0, res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic [31:0] last_result;
    logic [15:0] done_count;
    logic        busy, timeout_err, overflow_err;

    int total = 0;
    int bad = 0;

    alu_cmd_driver dut (
        .clk(clk), .reset_n(reset_n), .cmd_push(cmd_push), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_full(cmd_full), .alu_valid(alu_valid),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ready(alu_ready),
        .res_valid(res_valid), .res_data(res_data), .last_result(last_result),
        .done_count(done_count), .busy(busy), .timeout_err(timeout_err),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        e_valid;
        logic [2:0]  e_op;
        logic [31:0] e_a, e_b;
        logic        e_busy;
        logic [15:0] e_done;
        logic [31:0] e_last;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".alu_valid"}, 64'(alu_valid), 0);
        chk({tag, ".alu_op"}, 64'(alu_op), 0);
        chk({tag, ".alu_a"}, 64'(alu_a), 0);
        chk({tag, ".alu_b"}, 64'(alu_b), 0);
        chk({tag, ".cmd_full"}, 64'(cmd_full), 0);
        chk({tag, ".busy"}, 64'(busy), 0);
        chk({tag, ".last_result"}, 64'(last_result), 0);
        chk({tag, ".done_count"}, 64'(done_count), 0);
        chk({tag, ".timeout_err"}, 64'(timeout_err), 0);
        chk({tag, ".overflow_err"}, 64'(overflow_err), 0);
    endtask

    task automatic do_reset(input string tag);
        cmd_push = 0; alu_ready = 0; res_valid = 0;
        reset_n = 0;
        #2;
        chk_zero(tag);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_push = 1; cmd_op = op; cmd_a = a; cmd_b = b;
        step();
        cmd_push = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (alu_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".wait_valid"}, 64'(alu_valid), 1);
    endtask

    task automatic respond(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res);
        wait_valid(tag);
        chk({tag, ".op"}, 64'(alu_op), 64'(op));
        chk({tag, ".a"}, 64'(alu_a), 64'(a));
        chk({tag, ".b"}, 64'(alu_b), 64'(b));
        alu_ready = 1;
        step();
        alu_ready = 0;
        chk({tag, ".xfer"}, 64'(alu_valid), 0);
        res_valid = 1; res_data = res;
        step();
        res_valid = 0;
        chk({tag, ".last"}, 64'(last_result), 64'(res));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        // Single ADD 5+7, ready always high, result 12 three edges after transfer (edge 2).
        tbl[0] = '{1, OP_ADD, 5, 7, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 0,      1, 0, 0,  1, OP_ADD, 5, 7, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 0,      1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 0,      1, 1, 12, 0, 0, 0, 0, 0, 1, 12};
        tbl[6] = '{0, 0, 0, 0,      0, 0, 0,  0, 0, 0, 0, 0, 1, 12};

        do_reset("rst0");

        for (int i = 0; i < 7; i++) begin
            cmd_push = tbl[i].push; cmd_op = tbl[i].op; cmd_a = tbl[i].a; cmd_b = tbl[i].b;
            alu_ready = tbl[i].rdy; res_valid = tbl[i].rv; res_data = tbl[i].rd;
            step();
            chk($sformatf("v%0d.valid", i), 64'(alu_valid), 64'(tbl[i].e_valid));
            chk($sformatf("v%0d.op", i), 64'(alu_op), 64'(tbl[i].e_op));
            chk($sformatf("v%0d.a", i), 64'(alu_a), 64'(tbl[i].e_a));
            chk($sformatf("v%0d.b", i), 64'(alu_b), 64'(tbl[i].e_b));
            chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d.done", i), 64'(done_count), 64'(tbl[i].e_done));
            chk($sformatf("v%0d.last", i), 64'(last_result), 64'(tbl[i].e_last));
        end
        cmd_push = 0; alu_ready = 0; res_valid = 0;

        // Fill to full with ready low, fifth push dropped, then drain in order.
        do_reset("rst1");
        for (int i = 0; i < 5; i++) begin
            push_cmd(3'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i));
            if (i == 2) chk("fill.full_after3", 64'(cmd_full), 0);
            if (i == 3) chk("fill.full_after4", 64'(cmd_full), 1);
            if (i == 3) chk("fill.ovf_after4", 64'(overflow_err), 0);
        end
        chk("fill.ovf_after5", 64'(overflow_err), 1);
        chk("fill.full_after5", 64'(cmd_full), 1);
        for (int i = 0; i < 4; i++)
            respond($sformatf("drain%0d", i), 3'(i + 1), 32'h100 + 32'(i),
                    32'h200 + 32'(i), 32'hA0 + 32'(i));
        chk("drain.done", 64'(done_count), 4);
        chk("drain.busy", 64'(busy), 0);
        chk("drain.ovf_sticky", 64'(overflow_err), 1);

        // Stall in ISSUE for 6 cycles: operands must hold.
        do_reset("rst2");
        push_cmd(OP_SUB, 32'hDEAD, 32'hBEEF);
        wait_valid("stall");
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("stall%0d.valid", i), 64'(alu_valid), 1);
            chk($sformatf("stall%0d.op", i), 64'(alu_op), 64'(OP_SUB));
            chk($sformatf("stall%0d.a", i), 64'(alu_a), 32'hDEAD);
            chk($sformatf("stall%0d.b", i), 64'(alu_b), 32'hBEEF);
        end
        alu_ready = 1;
        step();
        alu_ready = 0;
        chk("stall.xfer", 64'(alu_valid), 0);
        chk("stall.busy", 64'(busy), 1);

        // Timeout with a second command queued behind it.
        do_reset("rst3");
        push_cmd(OP_AND, 32'h111, 32'h1);
        push_cmd(OP_OR, 32'h222, 32'h2);
        wait_valid("to");
        chk("to.first_a", 64'(alu_a), 32'h111);
        alu_ready = 1;
        step();
        alu_ready = 0;
        repeat (15) step();
        chk("to.before", 64'(timeout_err), 0);
        step();
        chk("to.err", 64'(timeout_err), 1);
        chk("to.done", 64'(done_count), 0);
        chk("to.next_valid", 64'(alu_valid), 1);
        chk("to.next_a", 64'(alu_a), 32'h222);
        respond("to.next", OP_OR, 32'h222, 32'h2, 32'h333);
        chk("to.done_after", 64'(done_count), 1);
        chk("to.sticky", 64'(timeout_err), 1);

        // Result on the timeout edge wins.
        do_reset("rst4");
        push_cmd(OP_XOR, 32'h5, 32'h6);
        wait_valid("edge");
        alu_ready = 1;
        step();
        alu_ready = 0;
        repeat (15) step();
        res_valid = 1; res_data = 32'h55;
        step();
        res_valid = 0;
        chk("edge.no_err", 64'(timeout_err), 0);
        chk("edge.done", 64'(done_count), 1);
        chk("edge.last", 64'(last_result), 32'h55);
        chk("edge.busy", 64'(busy), 0);

        // Reset while waiting for a result with three commands queued.
        do_reset("rst5");
        for (int i = 0; i < 5; i++) push_cmd(OP_ADD, 32'(i), 32'(i));
        wait_valid("mid");
        alu_ready = 1;
        step();
        alu_ready = 0;
        chk("mid.busy", 64'(busy), 1);
        chk("mid.full", 64'(cmd_full), 0);
        chk("mid.ovf", 64'(overflow_err), 1);
        #2;
        reset_n = 0;
        #1;
        chk_zero("mid.rst");
        @(negedge clk);
        reset_n = 1;
        repeat (3) step();
        chk("post.busy", 64'(busy), 0);
        chk("post.valid", 64'(alu_valid), 0);
        chk("post.done", 64'(done_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
